fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch stage and id_stage.
//  Decouples imem fetch rate from decode stalls.
//  Stores fetched {pc, instr} pairs in order, in a circular FIFO.
//  Presents the oldest pair to decode with a valid/ready handshake.
//  Discards all contents on a branch/exception redirect (flush).
// PARAMETERS
//  DEPTH  8   entries; power of 2, >= 2
//  XLEN   32  width of pc and instr
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             async reset, active-high
//  flush      in   1             sync redirect; discards all entries
//  enq_valid  in   1             fetch presents a pair
//  enq_ready  out  1             queue accepts a pair (= !full)
//  enq_pc     in   XLEN          pc of fetched instr
//  enq_instr  in   XLEN          fetched instruction word
//  deq_valid  out  1             head entry valid toward id_stage
//  deq_ready  in   1             id_stage consumes head
//  deq_pc     out  XLEN          head pc
//  deq_instr  out  XLEN          head instr
//  count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset:
//   - One clock; reset is asynchronous and active-high.
//   - While reset is high, rd_ptr, wr_ptr and count are held at 0.
//   - Outputs during and after reset: deq_valid=0, deq_pc=0, deq_instr=0, enq_ready=1.
//   - Storage array is not reset.
//  Pointers:
//   - rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//   - empty = (ptrs equal). full = (index bits equal, wrap bits differ).
//   - Index wraps from DEPTH-1 to 0 and toggles the wrap bit.
//  Handshakes:
//   - Enqueue when enq_valid&enq_ready: write at wr_ptr, wr_ptr+1.
//   - Dequeue when deq_valid&deq_ready: rd_ptr+1.
//   - enq_ready=!full, independent of deq_ready. No enqueue when full, even if a dequeue happens that cycle.
//   - enq_valid while full is ignored. Fetch holds its data.
//   - deq_valid=!empty. deq_pc/deq_instr = storage[rd_ptr] when valid, else 0.
//  Simultaneous events:
//   - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
//   - Dequeue the last entry and enqueue in the same cycle: the new entry is visible the next cycle.
//  Flush:
//   - Takes priority over everything.
//   - Next cycle: rd_ptr=wr_ptr=0, count=0, deq_valid=0.
//   - An enqueue offered in the flush cycle is dropped.
//   - A dequeue in the flush cycle is a don't-care for the queue; id_stage discards it.
//  Latency: an enqueued entry reaches deq_* 1 cycle later (registered storage read path).
//  count: registered, equals wr_ptr-rd_ptr modulo 2*DEPTH, range 0..DEPTH.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined:
//   - When empty and enq_valid=1 and flush=0: deq_valid=1 combinationally, deq_pc/deq_instr = enq_*.
//   - If deq_ready=1 in that cycle: the entry is consumed without being written. Pointers and count stay 0.
//   - If deq_ready=0: the entry is written normally.
//   - Zero-cycle latency when empty.
//  Not defined: no combinational enq->deq path; minimum latency is 1 cycle.
// TESTING
//  1. Reset mid-operation with 3 entries: assert reset -> count=0, deq_valid=0, enq_ready=1 immediately.
//  2. Fill: enqueue 8 pairs (pc 0x100..0x11C) with deq_ready=0 -> count=8, enq_ready=0.
//     A 9th enq_valid is ignored. Drain order is pc 0x100..0x11C.
//  3. Wrap: 20 cycles of steady enq+deq with 4 entries resident -> count stays 4, order preserved across index 7->0.
//  4. Simultaneous enq+deq when full (count=8) -> enq refused, count=7 next cycle.
//  5. Flush with 5 entries plus enq_valid (pc 0x200) -> next cycle count=0, deq_valid=0, pc 0x200 never dequeued.
//  6. Bypass: empty, enq pc 0x300, deq_ready=1.
//     With FETCH_QUEUE_BYPASS_EN: deq_valid=1, deq_pc=0x300 same cycle, count stays 0.
//     Without: deq_pc=0x300 one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and id_stage.
// A circular FIFO of {pc, instr} pairs with valid/ready handshakes on both
// sides and a synchronous flush for branch/exception redirects.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an incoming
// pair straight to decode when the queue is empty (zero-cycle latency).
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [XLEN-1:0]          enq_instr,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit above the index so full and empty
  // can be told apart when the indices match.
  logic [AW:0]     rd_ptr;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     count_q;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic empty;
  logic full;
  logic stored_valid;
  logic bypass_active;
  logic bypass_take;
  logic do_enq;
  logic do_deq;

  assign empty        = (rd_ptr == wr_ptr);
  assign full         = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign stored_valid = !empty;
  assign enq_ready    = !full;
  assign count        = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the offered pair to decode in the same cycle;
  // if decode takes it, it is never written so the pointers stay put.
  assign bypass_active = empty && enq_valid && !flush && !reset;
  assign bypass_take   = bypass_active && deq_ready;
`else
  assign bypass_active = 1'b0;
  assign bypass_take   = 1'b0;
`endif

  // Flush wins over both handshakes; a full queue refuses new pairs even
  // when decode frees a slot in the same cycle.
  assign do_enq = enq_valid && !full && !flush && !bypass_take;
  assign do_deq = stored_valid && deq_ready && !flush;

  // Head presentation: stored entry first, then bypassed pair, else zeros.
  always_comb begin
    deq_valid = 1'b0;
    deq_pc    = '0;
    deq_instr = '0;
    if (stored_valid) begin
      deq_valid = 1'b1;
      deq_pc    = pc_mem[rd_ptr[AW-1:0]];
      deq_instr = instr_mem[rd_ptr[AW-1:0]];
    end else if (bypass_active) begin
      deq_valid = 1'b1;
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end
  end

  // Pointer and occupancy registers; flush returns everything to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are left unreset since validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem[wr_ptr[AW-1:0]]    <= enq_pc;
      instr_mem[wr_ptr[AW-1:0]] <= enq_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// Inputs change shortly after the falling edge; outputs are checked 1ns
// later, well away from the rising edge that samples them.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;
  logic [3:0]      count;

  int passed;
  int total;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Move to the next drive point with all handshakes idle.
  task automatic idle_cycle();
    @(negedge clk);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    enq_pc    = '0;
    enq_instr = '0;
    #1;
  endtask

  // Offer one pair at the next drive point, with a chosen deq_ready.
  task automatic offer(input logic [XLEN-1:0] pc, input logic rdy);
    @(negedge clk);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_instr = instr_of(pc);
    deq_ready = rdy;
    flush     = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (count !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passed++;
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL reset_deq_valid: got %b expected 0", deq_valid); else passed++;
    total++; if (deq_pc !== 32'h0) $display("[TB] FAIL reset_deq_pc: got %h expected 0", deq_pc); else passed++;
    total++; if (enq_ready !== 1'b1) $display("[TB] FAIL reset_enq_ready: got %b expected 1", enq_ready); else passed++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) offer(32'h10 + 4 * i, 1'b0);
    idle_cycle();
    total++; if (count !== 4'd3) $display("[TB] FAIL pre_reset_count: got %0d expected 3", count); else passed++;
    #1;
    reset = 1'b1;
    #1;
    total++; if (count !== 4'd0) $display("[TB] FAIL midreset_count: got %0d expected 0", count); else passed++;
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL midreset_deq_valid: got %b expected 0", deq_valid); else passed++;
    total++; if (enq_ready !== 1'b1) $display("[TB] FAIL midreset_enq_ready: got %b expected 1", enq_ready); else passed++;
    idle_cycle();
    reset = 1'b0;
    idle_cycle();
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL post_reset_deq_valid: got %b expected 0", deq_valid); else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) offer(32'h100 + 4 * i, 1'b0);
    offer(32'h999, 1'b0);
    total++; if (count !== 4'd8) $display("[TB] FAIL fill_count: got %0d expected 8", count); else passed++;
    total++; if (enq_ready !== 1'b0) $display("[TB] FAIL fill_enq_ready: got %b expected 0", enq_ready); else passed++;
    idle_cycle();
    total++; if (count !== 4'd8) $display("[TB] FAIL ninth_ignored_count: got %0d expected 8", count); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      deq_ready = 1'b1;
      #1;
      total++; if (deq_valid !== 1'b1) $display("[TB] FAIL drain_valid_%0d: got %b expected 1", i, deq_valid); else passed++;
      total++; if (deq_pc !== 32'h100 + 4 * i) $display("[TB] FAIL drain_pc_%0d: got %h expected %h", i, deq_pc, 32'h100 + 4 * i); else passed++;
      total++; if (deq_instr !== instr_of(32'h100 + 4 * i)) $display("[TB] FAIL drain_instr_%0d: got %h expected %h", i, deq_instr, instr_of(32'h100 + 4 * i)); else passed++;
    end
    idle_cycle();
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL drained_valid: got %b expected 0", deq_valid); else passed++;
    total++; if (count !== 4'd0) $display("[TB] FAIL drained_count: got %0d expected 0", count); else passed++;
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] head;
    for (int i = 0; i < 4; i++) offer(32'h400 + 4 * i, 1'b0);
    for (int j = 0; j < 20; j++) begin
      head = 32'h400 + 4 * j;
      offer(32'h400 + 4 * (j + 4), 1'b1);
      total++; if (deq_pc !== head) $display("[TB] FAIL wrap_pc_%0d: got %h expected %h", j, deq_pc, head); else passed++;
      total++; if (count !== 4'd4) $display("[TB] FAIL wrap_count_%0d: got %0d expected 4", j, count); else passed++;
    end
    for (int j = 20; j < 24; j++) begin
      head = 32'h400 + 4 * j;
      @(negedge clk);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      #1;
      total++; if (deq_pc !== head) $display("[TB] FAIL wrap_tail_pc_%0d: got %h expected %h", j, deq_pc, head); else passed++;
    end
    idle_cycle();
    total++; if (count !== 4'd0) $display("[TB] FAIL wrap_end_count: got %0d expected 0", count); else passed++;
  endtask

  task automatic test_full_simultaneous();
    for (int i = 0; i < 8; i++) offer(32'h500 + 4 * i, 1'b0);
    offer(32'h600, 1'b1);
    total++; if (enq_ready !== 1'b0) $display("[TB] FAIL full_simul_enq_ready: got %b expected 0", enq_ready); else passed++;
    total++; if (deq_pc !== 32'h500) $display("[TB] FAIL full_simul_head: got %h expected 00000500", deq_pc); else passed++;
    idle_cycle();
    total++; if (count !== 4'd7) $display("[TB] FAIL full_simul_count: got %0d expected 7", count); else passed++;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      deq_ready = 1'b1;
      #1;
      total++; if (deq_pc !== 32'h500 + 4 * i) $display("[TB] FAIL full_simul_drain_%0d: got %h expected %h", i, deq_pc, 32'h500 + 4 * i); else passed++;
    end
    idle_cycle();
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL full_simul_refused_entry: got %b expected 0", deq_valid); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) offer(32'h700 + 4 * i, 1'b0);
    @(negedge clk);
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_pc    = 32'h200;
    enq_instr = instr_of(32'h200);
    #1;
    idle_cycle();
    total++; if (count !== 4'd0) $display("[TB] FAIL flush_count: got %0d expected 0", count); else passed++;
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL flush_deq_valid: got %b expected 0", deq_valid); else passed++;
    total++; if (deq_pc !== 32'h0) $display("[TB] FAIL flush_deq_pc: got %h expected 0", deq_pc); else passed++;
    total++; if (enq_ready !== 1'b1) $display("[TB] FAIL flush_enq_ready: got %b expected 1", enq_ready); else passed++;
    idle_cycle();
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL flush_dropped_enq: got %b expected 0", deq_valid); else passed++;
  endtask

  task automatic test_bypass();
    offer(32'h300, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    total++; if (deq_valid !== 1'b1) $display("[TB] FAIL bypass_valid: got %b expected 1", deq_valid); else passed++;
    total++; if (deq_pc !== 32'h300) $display("[TB] FAIL bypass_pc: got %h expected 00000300", deq_pc); else passed++;
    total++; if (count !== 4'd0) $display("[TB] FAIL bypass_count_same: got %0d expected 0", count); else passed++;
    idle_cycle();
    total++; if (count !== 4'd0) $display("[TB] FAIL bypass_count_next: got %0d expected 0", count); else passed++;
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL bypass_consumed: got %b expected 0", deq_valid); else passed++;
    offer(32'h304, 1'b0);
    total++; if (deq_pc !== 32'h304) $display("[TB] FAIL bypass_stall_pc: got %h expected 00000304", deq_pc); else passed++;
    idle_cycle();
    total++; if (count !== 4'd1) $display("[TB] FAIL bypass_stall_written: got %0d expected 1", count); else passed++;
    @(negedge clk);
    deq_ready = 1'b1;
    #1;
    total++; if (deq_pc !== 32'h304) $display("[TB] FAIL bypass_stall_head: got %h expected 00000304", deq_pc); else passed++;
`else
    total++; if (deq_valid !== 1'b0) $display("[TB] FAIL nobypass_valid_same: got %b expected 0", deq_valid); else passed++;
    total++; if (deq_pc !== 32'h0) $display("[TB] FAIL nobypass_pc_same: got %h expected 0", deq_pc); else passed++;
    @(negedge clk);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    #1;
    total++; if (deq_valid !== 1'b1) $display("[TB] FAIL nobypass_valid_next: got %b expected 1", deq_valid); else passed++;
    total++; if (deq_pc !== 32'h300) $display("[TB] FAIL nobypass_pc_next: got %h expected 00000300", deq_pc); else passed++;
    total++; if (count !== 4'd1) $display("[TB] FAIL nobypass_count: got %0d expected 1", count); else passed++;
`endif
    idle_cycle();
    total++; if (count !== 4'd0) $display("[TB] FAIL bypass_end_count: got %0d expected 0", count); else passed++;
  endtask

  // Scenario sequence.
  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_pc    = '0;
    enq_instr = '0;
    test_reset();
    test_fill();
    test_wrap();
    test_full_simultaneous();
    test_flush();
    test_bypass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
